// File: rtl/router_ctrl_fsm_pkg.sv
// Shared types and constants for the 1x3 router write controller.
// State encodings are fixed because router_reg and the debug taps decode them.
package router_pkg;
  localparam int NUM_CH  = 3;
  localparam int TIMEOUT = 30;
  localparam int CW      = 5;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] a);
    return NUM_CH'(3'b001 << a);
  endfunction
endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Handshake and status bundle between the source/router_reg/FIFO side and the write controller.
interface router_ctrl_fsm_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [1:0]        data_in;
  logic              parity_done;
  logic              low_packet_valid;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full_ch;
  logic [NUM_CH-1:0] read_enb;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              busy;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;

  modport master (
    output pkt_valid, data_in, parity_done, low_packet_valid,
           fifo_empty, fifo_full_ch, read_enb,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, write_enb, fifo_full, vld_out, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, parity_done, low_packet_valid,
           fifo_empty, fifo_full_ch, read_enb,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, write_enb, fifo_full, vld_out, soft_reset
  );
endinterface

// File: rtl/router_ctrl_fsm_timeout_ctr.sv
// Read-timeout watchdog for one output FIFO: flushes it when data sits unread too long.
module router_timeout_ctr #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          soft_reset_q, soft_reset_d;

  // A read on the terminal cycle takes priority, so a consumer that just woke up is never flushed.
  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (!vld || read_enb) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      soft_reset_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;
endmodule

// File: rtl/router_ctrl_fsm.sv
// Packet-write controller for the 1x3 router: header decode, write phase sequencing,
// one-hot FIFO write enables and per-channel read-timeout flushes.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT,
  parameter int CNT_W       = CW
) (
  input  logic         clock,
  input  logic         resetn,
  router_ctrl_fsm_if.slave bus
);
  state_t            state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic              addr_ok;
  logic              fifo_full_sel;
  logic [NUM_CH-1:0] vld_w;
  logic [NUM_CH-1:0] soft_reset_w;

  assign addr_ok       = (bus.data_in != ADDR_INVALID);
  assign fifo_full_sel = bus.fifo_full_ch[addr_q];
  assign vld_w         = ~bus.fifo_empty;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DA: begin
        if (bus.pkt_valid && addr_ok) begin
          addr_d  = bus.data_in;
          state_d = bus.fifo_empty[bus.data_in] ? LFD : WTE;
        end
      end
      LFD: state_d = LD;
      LD: begin
        if (fifo_full_sel)       state_d = FFS;
        else if (!bus.pkt_valid) state_d = LP;
      end
      FFS: if (!fifo_full_sel) state_d = LAF;
      LAF: begin
        if (bus.parity_done)           state_d = DA;
        else if (bus.low_packet_valid) state_d = LP;
        else                           state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = fifo_full_sel ? FFS : DA;
      WTE: if (bus.fifo_empty[addr_q]) state_d = LFD;
      default: state_d = DA;
    endcase
    // A flush of the channel being written abandons the packet.
    if (state_q != DA && soft_reset_w[addr_q]) state_d = DA;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.detect_add    = (state_q == DA);
  assign bus.lfd_state     = (state_q == LFD);
  assign bus.ld_state      = (state_q == LD);
  assign bus.laf_state     = (state_q == LAF);
  assign bus.full_state    = (state_q == FFS);
  assign bus.rst_int_reg   = (state_q == CPE);
  assign bus.write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
  assign bus.busy          = !((state_q == DA) || (state_q == LD));
  assign bus.write_enb     = bus.write_enb_reg ? ch_onehot(addr_q) : '0;
  assign bus.fifo_full     = fifo_full_sel;
  assign bus.vld_out       = vld_w;
  assign bus.soft_reset    = soft_reset_w;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_timeout
    router_timeout_ctr #(
      .TIMEOUT(TIMEOUT_CYC),
      .CW     (CNT_W)
    ) u_timeout (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_w[gi]),
      .read_enb  (bus.read_enb[gi]),
      .soft_reset(soft_reset_w[gi])
    );
  end
endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: the driver queues expected outputs, the monitor compares after each edge.
module tb_router_ctrl_fsm;
  import router_pkg::*;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_ctrl_fsm_if bus ();

  router_ctrl_fsm dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [17:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Bit order: detect,lfd,ld,laf,full,rst_int,wer,busy,write_enb[2:0],fifo_full,soft_reset[2:0],vld_out[2:0]
  function automatic logic [17:0] ex(state_t st, logic [1:0] a, logic [2:0] sr);
    logic       wer, busy;
    logic [2:0] we;
    wer  = (st == LD) || (st == LP) || (st == LAF);
    busy = (st == LFD) || (st == FFS) || (st == LAF) || (st == LP) || (st == CPE) || (st == WTE);
    we   = 3'b000;
    if (wer) we = (a == 2'd0) ? 3'b001 : (a == 2'd1) ? 3'b010 : 3'b100;
    return {st == DA, st == LFD, st == LD, st == LAF, st == FFS, st == CPE, wer, busy,
            we, bus.fifo_full_ch[a], sr, ~bus.fifo_empty};
  endfunction

  task automatic push(string n, state_t st, logic [1:0] a, logic [2:0] sr = 3'b000);
    exp_t e;
    e.name = n;
    e.exp  = ex(st, a, sr);
    q.push_back(e);
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  // Monitor: compares whatever the driver queued before the edge just taken.
  initial begin
    logic [17:0] got;
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
               bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.write_enb, bus.fifo_full,
               bus.soft_reset, bus.vld_out};
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s: got=%b expected=%b", e.name, got, e.exp);
        end
        $display("check %0d %s outputs=%b", checks, e.name, got);
      end
    end
  end

  initial begin
    int budget;
    bus.pkt_valid        = 1'b0;
    bus.data_in          = 2'b00;
    bus.parity_done      = 1'b0;
    bus.low_packet_valid = 1'b0;
    bus.fifo_empty       = 3'b111;
    bus.fifo_full_ch     = 3'b000;
    bus.read_enb         = 3'b000;

    // Reset state
    nxt(); push("reset", DA, 2'd0);
    nxt(); push("reset_hold", DA, 2'd0);

    // 1: header to ch1, payload, drop pkt_valid
    nxt(); resetn = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 2'b01; push("t1_lfd", LFD, 2'd1);
    nxt(); bus.data_in = 2'b10; push("t1_ld", LD, 2'd1);
    nxt(); bus.pkt_valid = 1'b0; push("t1_lp", LP, 2'd1);
    nxt(); push("t1_cpe", CPE, 2'd1);
    nxt(); push("t1_da", DA, 2'd1);

    // 2: invalid address stays in DA
    nxt(); bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("t2_da%0d", i), DA, 2'd1);
      nxt();
    end

    // 3: ch2 not empty -> WTE, then LFD once it drains
    bus.data_in = 2'b10; bus.fifo_empty = 3'b011; push("t3_wte", WTE, 2'd2);
    nxt(); bus.data_in = 2'b00; push("t3_wte_hold", WTE, 2'd2);
    nxt(); bus.fifo_empty = 3'b111; push("t3_lfd", LFD, 2'd2);
    nxt(); push("t3_ld", LD, 2'd2);
    nxt(); bus.pkt_valid = 1'b0; push("t3_lp", LP, 2'd2);
    nxt(); push("t3_cpe", CPE, 2'd2);
    nxt(); push("t3_da", DA, 2'd2);

    // 4: full stall on ch0, resume via LAF, then parity_done exit
    nxt(); bus.pkt_valid = 1'b1; bus.data_in = 2'b00; push("t4_lfd", LFD, 2'd0);
    nxt(); push("t4_ld", LD, 2'd0);
    nxt(); bus.fifo_full_ch = 3'b001; push("t4_ffs", FFS, 2'd0);
    nxt(); push("t4_ffs_hold", FFS, 2'd0);
    nxt(); bus.fifo_full_ch = 3'b000; push("t4_laf", LAF, 2'd0);
    nxt(); push("t4_laf_ld", LD, 2'd0);
    nxt(); bus.fifo_full_ch = 3'b001; push("t4_ffs2", FFS, 2'd0);
    nxt(); bus.fifo_full_ch = 3'b000; push("t4_laf2", LAF, 2'd0);
    nxt(); bus.parity_done = 1'b1; push("t4_laf_da", DA, 2'd0);
    nxt(); bus.parity_done = 1'b0; bus.pkt_valid = 1'b0; push("t4_idle", DA, 2'd0);

    // 5: ch1 timeout while writing to ch1 aborts the packet
    nxt(); bus.pkt_valid = 1'b1; bus.data_in = 2'b01; push("t5_lfd", LFD, 2'd1);
    nxt(); bus.fifo_empty = 3'b101;
    for (int i = 1; i <= 29; i++) begin
      push($sformatf("t5_ld%0d", i), LD, 2'd1);
      nxt();
    end
    push("t5_pulse", LD, 2'd1, 3'b010);
    nxt(); bus.pkt_valid = 1'b0; push("t5_abort", DA, 2'd1);
    nxt(); bus.fifo_empty = 3'b111; push("t5_idle", DA, 2'd1);

    // 5b: read on the terminal cycle suppresses the pulse
    nxt(); bus.fifo_empty = 3'b101;
    for (int i = 1; i <= 29; i++) begin
      push($sformatf("t5b_cnt%0d", i), DA, 2'd1);
      nxt();
    end
    bus.read_enb = 3'b010; push("t5b_read_wins", DA, 2'd1);
    nxt(); bus.read_enb = 3'b000; push("t5b_no_pulse", DA, 2'd1);
    nxt(); bus.fifo_empty = 3'b111; push("t5b_idle", DA, 2'd1);

    // 6: reset while in FFS, with ch2 counter running
    nxt(); bus.pkt_valid = 1'b1; bus.data_in = 2'b00; bus.fifo_empty = 3'b011; push("t6_lfd", LFD, 2'd0);
    nxt(); push("t6_ld", LD, 2'd0);
    nxt(); bus.fifo_full_ch = 3'b001; push("t6_ffs", FFS, 2'd0);
    nxt(); resetn = 1'b0; bus.pkt_valid = 1'b0; bus.fifo_full_ch = 3'b000; bus.fifo_empty = 3'b111;
    push("t6_reset", DA, 2'd0);
    // Counters were cleared: 29 idle edges with vld high must not pulse
    nxt(); resetn = 1'b1; bus.fifo_empty = 3'b011;
    for (int i = 1; i <= 29; i++) begin
      if (i == 29) push("t6_cnt_cleared", DA, 2'd0);
      nxt();
    end
    bus.fifo_empty = 3'b111;

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
